// File: rtl/wb_port_arbiter_if.sv
// Writeback port arbitration bus: requester results in, grant/stall and
// register-file write controls out.
interface wb_port_arbiter_if #(
  parameter int unsigned AW = 5
);

  logic [2:0]    req;
  logic [AW-1:0] rd0;
  logic [AW-1:0] rd1;
  logic [AW-1:0] rd2;
  logic [2:0]    gnt;
  logic [2:0]    stall;
  logic [1:0]    mux_sel;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;

  // Writeback sources (ALU, FPU, LSU) present results and consume grants
  modport master (
    output req, rd0, rd1, rd2,
    input  gnt, stall, mux_sel, rf_we, rf_waddr
  );

  // Arbiter side
  modport slave (
    input  req, rd0, rd1, rd2,
    output gnt, stall, mux_sel, rf_we, rf_waddr
  );

endinterface

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the single register-file write port among the ALU
// pipe (src 0), FPU (src 1) and load/store unit (src 2). One grant per cycle,
// zero-latency (outputs are combinational from req/rd and registered state).
// Default build: fixed priority 0 > 1 > 2 with per-source aging; a source
// refused MAX_WAIT times becomes urgent and outranks non-urgent sources.
// Build macro WB_ARB_RR_EN: replaces priority/aging with a 3-way round-robin.
// Writes to x0 are granted and consumed but never enable the RF write.
module wb_port_arbiter #(
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned AW       = 5
) (
  input  logic             clk,
  input  logic             reset,
  wb_port_arbiter_if.slave bus
);

  localparam int unsigned NSRC = 3;
  localparam int unsigned CW   = 4;
  localparam int unsigned SW   = 2;

  // Aging counter is 4 bits wide and the starvation bound needs at least 2
  if (MAX_WAIT < 2 || MAX_WAIT > 15) begin : g_bad_max_wait
    $error("wb_port_arbiter: MAX_WAIT must be within 2..15");
  end

  logic [SW-1:0]   gnt_idx_c;
  logic            gnt_vld_c;
  logic [NSRC-1:0] gnt_c;
  logic [AW-1:0]   gnt_rd_c;

`ifdef WB_ARB_RR_EN

  logic [SW-1:0] ptr;
  logic [SW-1:0] cand0_c;
  logic [SW-1:0] cand1_c;
  logic [SW-1:0] cand2_c;
  logic [3:0]    req_ext_c;

  // Next source index modulo 3
  function automatic logic [SW-1:0] next_src(input logic [SW-1:0] s);
    case (s)
      2'd0:    return 2'd1;
      2'd1:    return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

  // Round-robin search starting at ptr
  always_comb begin
    cand0_c   = ptr;
    cand1_c   = next_src(ptr);
    cand2_c   = next_src(cand1_c);
    req_ext_c = {1'b0, bus.req};
    gnt_vld_c = 1'b1;
    gnt_idx_c = 2'd0;
    if (req_ext_c[cand0_c]) begin
      gnt_idx_c = cand0_c;
    end else if (req_ext_c[cand1_c]) begin
      gnt_idx_c = cand1_c;
    end else if (req_ext_c[cand2_c]) begin
      gnt_idx_c = cand2_c;
    end else begin
      gnt_vld_c = 1'b0;
    end
  end

  // Pointer moves past the winner; held on idle cycles
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= 2'd0;
    end else if (gnt_vld_c) begin
      ptr <= next_src(gnt_idx_c);
    end
  end

`else

  logic [NSRC-1:0][CW-1:0] wait_cnt;
  logic [NSRC-1:0]         urgent_c;

  // A requester that has been refused MAX_WAIT times is urgent
  always_comb begin
    urgent_c = '0;
    for (int i = 0; i < int'(NSRC); i++) begin
      urgent_c[i] = bus.req[i] & (wait_cnt[i] == CW'(MAX_WAIT));
    end
  end

  // Lowest-index urgent source first, else fixed priority 0 > 1 > 2
  always_comb begin
    gnt_vld_c = 1'b1;
    gnt_idx_c = 2'd0;
    if (urgent_c[0]) begin
      gnt_idx_c = 2'd0;
    end else if (urgent_c[1]) begin
      gnt_idx_c = 2'd1;
    end else if (urgent_c[2]) begin
      gnt_idx_c = 2'd2;
    end else if (bus.req[0]) begin
      gnt_idx_c = 2'd0;
    end else if (bus.req[1]) begin
      gnt_idx_c = 2'd1;
    end else if (bus.req[2]) begin
      gnt_idx_c = 2'd2;
    end else begin
      gnt_vld_c = 1'b0;
    end
  end

  // Age refused requesters (saturating); clear on grant or no request
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else begin
      for (int i = 0; i < int'(NSRC); i++) begin
        if (bus.req[i] & ~gnt_c[i]) begin
          if (wait_cnt[i] != CW'(MAX_WAIT)) begin
            wait_cnt[i] <= wait_cnt[i] + CW'(1);
          end
        end else begin
          wait_cnt[i] <= '0;
        end
      end
    end
  end

`endif

  // One-hot grant vector from the winning index
  always_comb begin
    gnt_c = '0;
    if (gnt_vld_c) begin
      case (gnt_idx_c)
        2'd0:    gnt_c = 3'b001;
        2'd1:    gnt_c = 3'b010;
        default: gnt_c = 3'b100;
      endcase
    end
  end

  // Destination register of the winning source
  always_comb begin
    case (gnt_idx_c)
      2'd0:    gnt_rd_c = bus.rd0;
      2'd1:    gnt_rd_c = bus.rd1;
      default: gnt_rd_c = bus.rd2;
    endcase
  end

  // Port drive; reset forces everything quiet immediately, killing any write
  always_comb begin
    bus.gnt      = '0;
    bus.stall    = '0;
    bus.mux_sel  = 2'd0;
    bus.rf_we    = 1'b0;
    bus.rf_waddr = '0;
    if (!reset) begin
      bus.gnt   = gnt_c;
      bus.stall = bus.req & ~gnt_c;
      if (gnt_vld_c) begin
        bus.mux_sel  = gnt_idx_c;
        bus.rf_waddr = gnt_rd_c;
        bus.rf_we    = (gnt_rd_c != '0);
      end
    end
  end

  // The mux select is always a real source index
  a_mux_sel_legal : assert property (@(posedge clk) disable iff (reset)
    bus.mux_sel != 2'd3);

  // At most one source granted per cycle
  a_gnt_onehot : assert property (@(posedge clk) disable iff (reset)
    $onehot0(bus.gnt));

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: directed scenarios with hand-derived
// expectations, then a randomized phase checked against a behavioural model.
module tb_wb_port_arbiter;

  localparam int unsigned MAX_WAIT = 4;
  localparam int unsigned AW       = 5;

  typedef struct packed {
    logic [2:0]    gnt;
    logic [2:0]    stall;
    logic [1:0]    sel;
    logic          we;
    logic [AW-1:0] waddr;
  } exp_t;

  logic  clk = 1'b0;
  logic  reset;
  int    n_checks = 0;
  int    n_fail   = 0;
  exp_t  exp_q[$];
  string tag_q[$];

  // Randomized phase state
  logic [2:0]    pend;
  logic [AW-1:0] rdv [3];
`ifdef WB_ARB_RR_EN
  int            mptr;
`else
  int            mcnt [3];
`endif

  wb_port_arbiter_if #(.AW(AW)) bus ();

  wb_port_arbiter #(.MAX_WAIT(MAX_WAIT), .AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Apply one cycle of stimulus and queue what the arbiter must answer
  task automatic drive_expect(input string tag, input logic [2:0] rq,
                              input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                              input logic [AW-1:0] a2, input logic [2:0] eg,
                              input logic [1:0] es, input logic ew,
                              input logic [AW-1:0] ea);
    exp_t e;
    bus.req = rq;
    bus.rd0 = a0;
    bus.rd1 = a1;
    bus.rd2 = a2;
    e.gnt   = eg;
    e.stall = reset ? 3'b000 : (rq & ~eg);
    e.sel   = es;
    e.we    = ew;
    e.waddr = ea;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic step(input string tag, input logic [2:0] rq,
                      input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                      input logic [AW-1:0] a2, input logic [2:0] eg,
                      input logic [1:0] es, input logic ew,
                      input logic [AW-1:0] ea);
    drive_expect(tag, rq, a0, a1, a2, eg, es, ew, ea);
    @(posedge clk);
    #1;
  endtask

  // Compare DUT outputs mid-cycle against the oldest queued expectation
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check({t, "/gnt"},      32'(bus.gnt),      32'(e.gnt));
      check({t, "/stall"},    32'(bus.stall),    32'(e.stall));
      check({t, "/mux_sel"},  32'(bus.mux_sel),  32'(e.sel));
      check({t, "/rf_we"},    32'(bus.rf_we),    32'(e.we));
      check({t, "/rf_waddr"}, 32'(bus.rf_waddr), 32'(e.waddr));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset   = 1'b1;
    bus.req = '0;
    bus.rd0 = '0;
    bus.rd1 = '0;
    bus.rd2 = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset held with all requesting: everything quiet
    step("t1_rst", 3'b111, 5'd5, 5'd7, 5'd9, 3'b000, 2'd0, 1'b0, 5'd0);
    reset = 1'b0;
    step("t1_rel", 3'b111, 5'd5, 5'd7, 5'd9, 3'b001, 2'd0, 1'b1, 5'd5);

`ifdef WB_ARB_RR_EN
    // Round-robin rotation and pointer hold across idle cycles
    step("t5_rr1", 3'b111, 5'd5, 5'd7, 5'd9, 3'b010, 2'd1, 1'b1, 5'd7);
    step("t5_rr2", 3'b111, 5'd5, 5'd7, 5'd9, 3'b100, 2'd2, 1'b1, 5'd9);
    step("t5_rr0", 3'b111, 5'd5, 5'd7, 5'd9, 3'b001, 2'd0, 1'b1, 5'd5);
    step("t5_idle", 3'b000, 5'd0, 5'd0, 5'd0, 3'b000, 2'd0, 1'b0, 5'd0);
    step("t5_idle", 3'b000, 5'd0, 5'd0, 5'd0, 3'b000, 2'd0, 1'b0, 5'd0);
    step("t5_ptr", 3'b011, 5'd5, 5'd7, 5'd9, 3'b010, 2'd1, 1'b1, 5'd7);
    step("idle", 3'b000, 5'd0, 5'd0, 5'd0, 3'b000, 2'd0, 1'b0, 5'd0);
`else
    // All three requesting: src 0 wins until 1 and 2 turn urgent together
    for (int c = 2; c <= 4; c++)
      step("t4_src0", 3'b111, 5'd5, 5'd7, 5'd9, 3'b001, 2'd0, 1'b1, 5'd5);
    step("t4_src1_urg", 3'b111, 5'd5, 5'd7, 5'd9, 3'b010, 2'd1, 1'b1, 5'd7);
    step("t4_src2_urg", 3'b111, 5'd5, 5'd7, 5'd9, 3'b100, 2'd2, 1'b1, 5'd9);
    step("idle", 3'b000, 5'd0, 5'd0, 5'd0, 3'b000, 2'd0, 1'b0, 5'd0);

    // Src 1 hogs the port until src 2 ages out
    for (int c = 1; c <= 4; c++)
      step("t2_src1", 3'b110, 5'd0, 5'd8, 5'd9, 3'b010, 2'd1, 1'b1, 5'd8);
    step("t2_src2_urg", 3'b110, 5'd0, 5'd8, 5'd9, 3'b100, 2'd2, 1'b1, 5'd9);
    step("idle", 3'b000, 5'd0, 5'd0, 5'd0, 3'b000, 2'd0, 1'b0, 5'd0);

    // x0 destination: granted, consumed, no RF write
    step("t3_x0", 3'b100, 5'd0, 5'd0, 5'd0, 3'b100, 2'd2, 1'b0, 5'd0);
    step("idle", 3'b000, 5'd0, 5'd0, 5'd0, 3'b000, 2'd0, 1'b0, 5'd0);

    // Age src 2 to 3, then reset in the middle of a src 1 grant
    for (int c = 1; c <= 3; c++)
      step("t6_pre", 3'b110, 5'd0, 5'd3, 5'd4, 3'b010, 2'd1, 1'b1, 5'd3);
    drive_expect("t6_pre", 3'b110, 5'd0, 5'd3, 5'd4, 3'b010, 2'd1, 1'b1, 5'd3);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("t6_rst/gnt",      32'(bus.gnt),      32'd0);
    check("t6_rst/rf_we",    32'(bus.rf_we),    32'd0);
    check("t6_rst/stall",    32'(bus.stall),    32'd0);
    check("t6_rst/mux_sel",  32'(bus.mux_sel),  32'd0);
    check("t6_rst/rf_waddr", 32'(bus.rf_waddr), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    // Counters restart from 0: src 2 needs four fresh refusals
    for (int c = 1; c <= 4; c++)
      step("t6_src1", 3'b110, 5'd0, 5'd3, 5'd4, 3'b010, 2'd1, 1'b1, 5'd3);
    step("t6_src2_urg", 3'b110, 5'd0, 5'd3, 5'd4, 3'b100, 2'd2, 1'b1, 5'd4);
    step("idle", 3'b000, 5'd0, 5'd0, 5'd0, 3'b000, 2'd0, 1'b0, 5'd0);
`endif

    // Randomized traffic against a behavioural model, from a clean reset
    bus.req = '0;
    reset   = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    pend  = '0;
    for (int i = 0; i < 3; i++) rdv[i] = '0;
`ifdef WB_ARB_RR_EN
    mptr = 0;
`else
    for (int i = 0; i < 3; i++) mcnt[i] = 0;
`endif

    for (int cyc = 0; cyc < 400; cyc++) begin
      int            g;
      logic [2:0]    eg;
      logic [1:0]    es;
      logic          ew;
      logic [AW-1:0] ea;
      for (int i = 0; i < 3; i++) begin
        if (!pend[i] && $urandom_range(0, 2) != 0) begin
          pend[i] = 1'b1;
          rdv[i]  = AW'($urandom_range(0, 31));
        end
      end
      g = -1;
`ifdef WB_ARB_RR_EN
      for (int k = 0; k < 3; k++) begin
        int idx;
        idx = (mptr + k) % 3;
        if (g < 0 && pend[idx]) g = idx;
      end
`else
      for (int i = 0; i < 3; i++)
        if (g < 0 && pend[i] && mcnt[i] == int'(MAX_WAIT)) g = i;
      for (int i = 0; i < 3; i++)
        if (g < 0 && pend[i]) g = i;
`endif
      eg = 3'b000;
      es = 2'd0;
      ew = 1'b0;
      ea = '0;
      if (g >= 0) begin
        eg = 3'(1 << g);
        es = 2'(g);
        ea = rdv[g];
        ew = (rdv[g] != '0);
      end
      drive_expect("rnd", pend, rdv[0], rdv[1], rdv[2], eg, es, ew, ea);
      @(posedge clk);
      #1;
`ifdef WB_ARB_RR_EN
      if (g >= 0) mptr = (g + 1) % 3;
`else
      for (int i = 0; i < 3; i++) begin
        if (pend[i] && g != i) mcnt[i] = (mcnt[i] < int'(MAX_WAIT)) ? mcnt[i] + 1 : int'(MAX_WAIT);
        else mcnt[i] = 0;
      end
`endif
      if (g >= 0) begin
        if ($urandom_range(0, 1) != 0) rdv[g] = AW'($urandom_range(0, 31));
        else pend[g] = 1'b0;
      end
    end

    bus.req = '0;
    @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
